// File: rtl/regfile_dump_ctrl_if.sv
// rtl/regfile_dump_ctrl_if.sv - dump word stream between the state dumper and its consumer
// Master drives the word and its valid; slave returns ready.
interface regfile_dump_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              out_valid;
  logic              out_ready;
  logic              out_is_pc;
  logic [ADDR_W-1:0] out_idx;
  logic [DATA_W-1:0] out_data;

  modport master (
    output out_valid,
    output out_is_pc,
    output out_idx,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_is_pc,
    input  out_idx,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/regfile_dump_ctrl.sv
// rtl/regfile_dump_ctrl.sv - end-of-program detector and PC/register-file dumper
// Runs until the PC self-loops or the cycle budget expires, then stalls the core and streams PC + registers.
module regfile_dump_ctrl #(
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 32,
  parameter int ADDR_W      = 5,
  parameter int CNT_W       = 16,
  parameter int MAX_CYCLES  = 1024,
  parameter int HALT_REPEAT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DATA_W-1:0]  pc,
  output logic [ADDR_W-1:0]  rf_raddr,
  input  logic [DATA_W-1:0]  rf_rdata,
  output logic               cpu_hold,
  regfile_dump_ctrl_if.master dump,
  output logic [CNT_W-1:0]   cycle_count,
  output logic               timeout,
  output logic               done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    SEND_PC = 3'd2,
    FETCH   = 3'd3,
    SEND    = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  stable;
  logic [DATA_W-1:0] pc_prev;
  logic              prev_valid;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] data_q;

  logic [CNT_W-1:0]  stable_next;
  logic [CNT_W-1:0]  count_next;
  logic              halt_hit;
  logic              budget_hit;
  logic              last_idx;

  logic              valid_c;
  logic              is_pc_c;
  logic [ADDR_W-1:0] idx_c;
  logic              hold_c;
  logic              done_c;

  // Stability and budget are judged on this cycle's values so the exit edge is the detecting edge.
  assign stable_next = (prev_valid && (pc == pc_prev)) ? stable + 1'b1 : '0;
  assign count_next  = cycle_count + 1'b1;
  assign halt_hit    = (stable_next == CNT_W'(HALT_REPEAT));
  assign budget_hit  = (count_next == CNT_W'(MAX_CYCLES));
  assign last_idx    = (idx == ADDR_W'(NUM_REGS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    valid_c    = 1'b0;
    is_pc_c    = 1'b0;
    idx_c      = '0;
    hold_c     = 1'b0;
    done_c     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        if (halt_hit || budget_hit) state_next = SEND_PC;
      end
      SEND_PC: begin
        valid_c = 1'b1;
        is_pc_c = 1'b1;
        hold_c  = 1'b1;
        if (dump.out_ready) state_next = FETCH;
      end
      FETCH: begin
        hold_c     = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        valid_c = 1'b1;
        idx_c   = idx;
        hold_c  = 1'b1;
        if (dump.out_ready) state_next = last_idx ? DONE : FETCH;
      end
      DONE: begin
        hold_c = 1'b1;
        done_c = 1'b1;
        if (start) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count <= '0;
      stable      <= '0;
      pc_prev     <= '0;
      prev_valid  <= 1'b0;
      timeout     <= 1'b0;
      idx         <= '0;
      data_q      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cycle_count <= '0;
            stable      <= '0;
            prev_valid  <= 1'b0;
            timeout     <= 1'b0;
            idx         <= '0;
          end
        end
        RUN: begin
          cycle_count <= count_next;
          stable      <= stable_next;
          pc_prev     <= pc;
          prev_valid  <= 1'b1;
          if (halt_hit || budget_hit) begin
            data_q  <= pc;
            timeout <= budget_hit && !halt_hit;
          end
        end
        SEND_PC: begin
          if (dump.out_ready) idx <= '0;
        end
        FETCH: begin
          data_q <= rf_rdata;
        end
        SEND: begin
          if (dump.out_ready && !last_idx) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rf_raddr       = idx;
  assign cpu_hold       = hold_c;
  assign done           = done_c;
  assign dump.out_valid = valid_c;
  assign dump.out_is_pc = is_pc_c;
  assign dump.out_idx   = idx_c;
  assign dump.out_data  = data_q;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// tb/tb_regfile_dump_ctrl.sv - directed bench for regfile_dump_ctrl
// Budget of 20 cycles lets halt, timeout and halt/timeout coincidence run on one instance.
module tb_regfile_dump_ctrl;
  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [DATA_W-1:0] pc = '0;
  logic [ADDR_W-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              cpu_hold;
  logic [CNT_W-1:0]  cycle_count;
  logic              timeout;
  logic              done;
  logic [DATA_W-1:0] rf [NREGS];

  int checks = 0;
  int errors = 0;
  int n_exit;
  int edges;
  int words;

  regfile_dump_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dif ();

  regfile_dump_ctrl #(
    .DATA_W(DATA_W), .NUM_REGS(NREGS), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
    .MAX_CYCLES(20), .HALT_REPEAT(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .cpu_hold(cpu_hold),
    .dump(dif), .cycle_count(cycle_count), .timeout(timeout), .done(done)
  );

  assign rf_rdata = rf[rf_raddr];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pc_for(input int mode, input int n, input logic [DATA_W-1:0] base);
    if (mode == 0) return (n <= 3) ? DATA_W'((n - 1) * 4) : 32'h8;
    if (mode == 1) return base + DATA_W'(4 * (n - 1));
    return (n <= 16) ? base + DATA_W'(4 * (n - 1)) : base + 32'd60;
  endfunction

  // Arms from IDLE/DONE and feeds the PC pattern until the core is held.
  task automatic run_prog(input int mode, input logic [DATA_W-1:0] base, output int n);
    n = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("arm_done", done, 0);
    chk("arm_cycle_count", cycle_count, 0);
    chk("arm_hold", cpu_hold, 0);
    while (n < 100) begin
      n++;
      pc = pc_for(mode, n, base);
      @(posedge clk); #1;
      if (cpu_hold) break;
    end
  endtask

  task automatic check_exit(input string tag, input int n, input int exp_n, input logic exp_to,
                            input logic [DATA_W-1:0] exp_pc);
    chk({tag, "_exit_cycle"}, n, exp_n);
    chk({tag, "_cycle_count"}, cycle_count, exp_n);
    chk({tag, "_timeout"}, timeout, exp_to);
    chk({tag, "_pc_word"}, {dif.out_valid, dif.out_is_pc, dif.out_idx, dif.out_data},
        {1'b1, 1'b1, 5'd0, exp_pc});
  endtask

  // pat 0: ready always high; pat 1: ready 1,0,0 repeating. stop_idx >= 0 returns while that register is offered.
  task automatic collect(input int pat, input int stop_idx, input logic [DATA_W-1:0] exp_pc,
                         output int n_edges, output int n_words);
    logic        stall;
    logic [37:0] held;
    logic [37:0] exp_word;
    n_edges = 0;
    n_words = 0;
    stall = 1'b0;
    held = '0;
    while (n_edges < 1000) begin
      if (stall)
        chk("stall_stable", {dif.out_valid, dif.out_is_pc, dif.out_idx, dif.out_data}, {1'b1, held});
      if (stop_idx >= 0 && dif.out_valid && !dif.out_is_pc && dif.out_idx == ADDR_W'(stop_idx)) begin
        start = 1'b0;
        return;
      end
      if (done) break;
      dif.out_ready = (pat == 0) ? 1'b1 : (n_edges % 3 == 0);
      start = dif.out_valid;
      if (dif.out_valid && dif.out_ready) begin
        if (n_words == 0) exp_word = {1'b1, 5'd0, exp_pc};
        else exp_word = {1'b0, ADDR_W'(n_words - 1), rf[n_words - 1]};
        chk("word", {dif.out_is_pc, dif.out_idx, dif.out_data}, exp_word);
        n_words++;
      end
      stall = dif.out_valid && !dif.out_ready;
      held = {dif.out_is_pc, dif.out_idx, dif.out_data};
      @(posedge clk); #1;
      n_edges++;
    end
    start = 1'b0;
    dif.out_ready = 1'b0;
    chk("done_high", done, 1);
    chk("word_count", n_words, 33);
    chk("done_hold", cpu_hold, 1);
    if (pat == 0) chk("dump_length", n_edges, 65);
  endtask

  initial begin
    dif.out_ready = 1'b0;
    for (int i = 0; i < NREGS; i++) rf[i] = 32'h1000 + i;

    #3;
    chk("reset_outputs", {dif.out_valid, dif.out_is_pc, dif.out_idx, dif.out_data, cpu_hold, done, timeout},
        '0);
    chk("reset_count", {rf_raddr, cycle_count}, '0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_outputs", {dif.out_valid, cpu_hold, done}, '0);

    run_prog(0, 32'h0, n_exit);
    check_exit("halt", n_exit, 7, 1'b0, 32'h8);
    collect(0, -1, 32'h8, edges, words);
    chk("done_cc_held", cycle_count, 7);

    run_prog(1, 32'h100, n_exit);
    check_exit("budget", n_exit, 20, 1'b1, 32'h14C);
    collect(1, -1, 32'h14C, edges, words);
    chk("done_timeout_held", timeout, 1);

    run_prog(2, 32'h200, n_exit);
    check_exit("tie", n_exit, 20, 1'b0, 32'h23C);
    collect(0, -1, 32'h23C, edges, words);

    run_prog(0, 32'h0, n_exit);
    check_exit("pre_reset", n_exit, 7, 1'b0, 32'h8);
    collect(0, 10, 32'h8, edges, words);
    chk("stop_reached", words, 11);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outputs", {dif.out_valid, cpu_hold, done, dif.out_idx}, '0);
    chk("async_reset_state", {rf_raddr, cycle_count, dif.out_data}, '0);
    dif.out_ready = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_idle", {dif.out_valid, cpu_hold, done}, '0);

    run_prog(0, 32'h0, n_exit);
    check_exit("post_reset", n_exit, 7, 1'b0, 32'h8);
    collect(1, -1, 32'h8, edges, words);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_dump_ctrl.md
# regfile_dump_ctrl

Synthesizable end-of-program state dumper for the MIPS core. It replaces fixed-delay register inspection with run-time detection of program completion: a halted PC (self-loop) or a cycle budget. It then stalls the core and streams the final PC and every register-file entry out over a valid/ready port. The block sits beside the core, taps the PC, and owns one register-file read port.

## Interface
- DATA_W, 32, register and PC data width
- NUM_REGS, 32, register-file entries to dump (≥2)
- ADDR_W, 5, register address width (2^ADDR_W ≥ NUM_REGS)
- CNT_W, 16, cycle counter width
- MAX_CYCLES, 1024, cycle budget before forced stop (1 ≤ MAX_CYCLES < 2^CNT_W)
- HALT_REPEAT, 4, consecutive unchanged-PC cycles that define a halt (≥1)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  arm/run pulse; sampled only in IDLE and DONE
- pc  in  DATA_W  current core PC
- rf_raddr  out  ADDR_W  register-file read address (combinational read port)
- rf_rdata  in  DATA_W  register-file read data
- cpu_hold  out  1  stall request to the core
- out_valid  out  1  dump word valid
- out_ready  in  1  consumer accepts word
- out_is_pc  out  1  current word is the PC
- out_idx  out  ADDR_W  register index of current word (0 when out_is_pc)
- out_data  out  DATA_W  dump word, registered
- cycle_count  out  CNT_W  RUN cycles elapsed, frozen after RUN
- timeout  out  1  run ended on budget, not halt
- done  out  1  dump complete

## Operation
- States: IDLE, RUN, SEND_PC, FETCH, SEND, DONE.
- IDLE: all outputs low. start=1 → RUN.
  - On entry: cycle_count=0, stable=0, timeout=0, prev-valid=0.
- RUN: each cycle, cycle_count+1 and pc_prev←pc.
  - If prev-valid and pc==pc_prev: stable+1. Otherwise stable=0.
  - Halt: stable reaches HALT_REPEAT this cycle → SEND_PC.
  - Budget: cycle_count reaches MAX_CYCLES this cycle → SEND_PC with timeout=1.
  - Both in the same cycle: halt wins, timeout=0.
  - The PC of the exiting cycle is latched into out_data.
- SEND_PC: out_valid=1, out_is_pc=1, out_idx=0. On handshake → FETCH with idx=0.
- FETCH: rf_raddr=idx. Capture rf_rdata into out_data. → SEND.
- SEND: out_valid=1, out_idx=idx, out_data held stable while out_ready=0.
  - On handshake: if idx==NUM_REGS-1 → DONE; otherwise idx+1 → FETCH.
- DONE: done=1, cycle_count/timeout held.
  - start=1 → RUN, re-arming exactly as from IDLE and clearing done.
- cpu_hold=1 in SEND_PC, FETCH, SEND and DONE; 0 in IDLE and RUN.
- start is ignored in RUN, SEND_PC, FETCH and SEND.
- rf_raddr holds idx in all non-FETCH states. Reset value is 0.

## Timing
- Reset: state=IDLE, all outputs 0, counters 0. Assertion clears all of these immediately and asynchronously, including mid-RUN or mid-dump: out_valid and cpu_hold drop without waiting for a clock.
- start sampled high at edge k → first RUN cycle is k..k+1.
- Constant PC from RUN start: exit after HALT_REPEAT+1 RUN cycles, cycle_count=HALT_REPEAT+1.
- out_valid first rises the cycle after the RUN exit edge.
- With out_ready tied high, the full dump takes 1+2·NUM_REGS cycles; done rises on the next edge.
- Handshake: a word transfers on any edge with out_valid & out_ready.
  - out_valid never drops without a transfer.
  - out_data, out_idx and out_is_pc are stable while stalled.
- cycle_count never wraps: the budget exit precedes overflow by construction.

## Test plan
- Halt detect: start, pc steps 0x0,0x4,0x8 then holds 0x8, HALT_REPEAT=4 → exit after RUN cycle 7, cycle_count=7, timeout=0, first word out_is_pc=1 with out_data=0x8.
- Timeout: MAX_CYCLES=20, pc incrementing by 4 every cycle → exit after 20 RUN cycles, timeout=1, PC word = value on the 20th RUN cycle.
- Dump order/back-pressure: register file preloaded reg[i]=0x1000+i, out_ready toggling 1,0,0,1…
  - Required: 33 words, PC first, then indices 0..31 with data 0x1000..0x101F in order.
  - No duplicates or drops; fields stable during stalls; done after the last handshake.
- Simultaneous halt and timeout: MAX_CYCLES=5, HALT_REPEAT=4, constant pc → exit at cycle 5 with timeout=0.
- Reset mid-dump: assert rst while in SEND with idx=10 → out_valid, cpu_hold and done are 0 before the next clock edge, state=IDLE; a fresh start then dumps the PC word and all registers from idx 0.
- Re-arm: start pulsed in DONE → done clears, cycle_count restarts from 0, second dump is complete and identical for an unchanged register file.
